// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpram_pkg
// Brief    : Shared types and helpers for the dpram_bank RAM (all builds,
//            including DPRAM_OUTPUT_REG_EN).
// Revision : 1.0
// ============================================================================
package dpram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } dpram_state_t;

  localparam int DEFAULT_WORD_SIZE = 64;
  localparam int BYTE_LANES        = DEFAULT_WORD_SIZE / 8;

  // Widest word the mask helper handles; callers cast down to their width.
  localparam int MAX_WORD_SIZE = 1024;
  localparam int MAX_LANES     = MAX_WORD_SIZE / 8;

  function automatic logic [MAX_WORD_SIZE-1:0] lane_mask_bits(
    input logic [MAX_LANES-1:0] lanes
  );
    logic [MAX_WORD_SIZE-1:0] bits;
    bits = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      bits[i*8 +: 8] = {8{lanes[i]}};
    end
    return bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_port.sv
`default_nettype none
// ============================================================================
// Module   : dpram_port
// Brief    : Per-port request qualification and read-valid pipeline; an
//            extra output stage is added when DPRAM_OUTPUT_REG_EN is defined.
// Revision : 1.0
// ============================================================================
module dpram_port #(
  parameter int WORD_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 idle_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic                 in_range_i,
  input  logic [WORD_SIZE-1:0] rdata_i,
  output logic                 wr_o,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 valid_o
);

  logic                 w_acc;
  logic                 w_rd;
  logic [WORD_SIZE-1:0] data_d;
  logic [WORD_SIZE-1:0] data_q;
  logic                 valid_q;

  assign w_acc  = idle_i & en_i;
  assign w_rd   = w_acc & ~we_i;
  assign wr_o   = w_acc & we_i & in_range_i;
  // Out-of-range reads still complete, but with zero data.
  assign data_d = in_range_i ? rdata_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= w_rd;
      if (w_rd) data_q <= data_d;
    end
  end

`ifdef DPRAM_OUTPUT_REG_EN
  logic [WORD_SIZE-1:0] data2_q;
  logic                 valid2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid2_q <= 1'b0;
      data2_q  <= '0;
    end else begin
      valid2_q <= valid_q;
      if (valid_q) data2_q <= data_q;
    end
  end

  assign data_o  = data2_q;
  assign valid_o = valid2_q;
`else
  assign data_o  = data_q;
  assign valid_o = valid_q;
`endif

endmodule
`default_nettype wire

// File: rtl/dpram_bank.sv
`default_nettype none
// ============================================================================
// Module   : dpram_bank
// Brief    : True dual-port byte-enable RAM with clear sequencer and collision
//            flag. Define DPRAM_OUTPUT_REG_EN for one extra output stage.
// Revision : 1.0
// ============================================================================
module dpram_bank
  import dpram_pkg::*;
#(
  parameter int WORD_SIZE     = 64,
  parameter int ADDR_SIZE     = 8,
  parameter int WORD_CAPACITY = 2**ADDR_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_req,
  output logic                   busy,
  input  logic                   en_1,
  input  logic                   en_2,
  input  logic                   write_enable_1,
  input  logic                   write_enable_2,
  input  logic [WORD_SIZE/8-1:0] byte_en_1,
  input  logic [WORD_SIZE/8-1:0] byte_en_2,
  input  logic [ADDR_SIZE-1:0]   address_1,
  input  logic [ADDR_SIZE-1:0]   address_2,
  input  logic [WORD_SIZE-1:0]   data_in_1,
  input  logic [WORD_SIZE-1:0]   data_in_2,
  output logic [WORD_SIZE-1:0]   output_1,
  output logic [WORD_SIZE-1:0]   output_2,
  output logic                   valid_1,
  output logic                   valid_2,
  output logic                   collision
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(WORD_CAPACITY - 1);

  dpram_state_t         state_q;
  logic [ADDR_SIZE-1:0] clr_cnt_q;
  logic                 busy_q;
  logic                 coll_d;
  logic                 coll_q;

  logic [WORD_SIZE-1:0] mem_q [WORD_CAPACITY];

  logic                 w_idle;
  logic                 w_in_range_1, w_in_range_2;
  logic                 w_wr_1, w_wr_2;
  logic [WORD_SIZE-1:0] w_bits_1, w_bits_2;
  logic [WORD_SIZE-1:0] w_rdata_1, w_rdata_2;
  logic [WORD_SIZE-1:0] w_word_1, w_word_2, w_base_1;

  assign w_idle = (state_q == IDLE);
  assign busy   = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_SIZE'(1);
          end
        end
        default: begin
          if (clear_req) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
      endcase
    end
  end

  generate
    if (WORD_CAPACITY >= 2**ADDR_SIZE) begin : g_full_range
      assign w_in_range_1 = 1'b1;
      assign w_in_range_2 = 1'b1;
    end else begin : g_part_range
      assign w_in_range_1 = (32'(address_1) < WORD_CAPACITY);
      assign w_in_range_2 = (32'(address_2) < WORD_CAPACITY);
    end
  endgenerate

  assign w_bits_1  = WORD_SIZE'(lane_mask_bits(MAX_LANES'(byte_en_1)));
  assign w_bits_2  = WORD_SIZE'(lane_mask_bits(MAX_LANES'(byte_en_2)));
  assign w_rdata_1 = mem_q[address_1];
  assign w_rdata_2 = mem_q[address_2];

  // Port 1 merges on top of port 2's result so shared lanes take port 1 data.
  always_comb begin
    w_word_2 = (w_rdata_2 & ~w_bits_2) | (data_in_2 & w_bits_2);
    w_base_1 = (w_wr_2 && (address_1 == address_2)) ? w_word_2 : w_rdata_1;
    w_word_1 = (w_base_1 & ~w_bits_1) | (data_in_1 & w_bits_1);
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      if (w_wr_2) mem_q[address_2] <= w_word_2;
      if (w_wr_1) mem_q[address_1] <= w_word_1;
    end
  end

  assign coll_d = w_wr_1 & w_wr_2 & (address_1 == address_2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= coll_d;
  end

`ifdef DPRAM_OUTPUT_REG_EN
  logic coll2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll2_q <= 1'b0;
    else     coll2_q <= coll_q;
  end

  assign collision = coll2_q;
`else
  assign collision = coll_q;
`endif

  dpram_port #(.WORD_SIZE(WORD_SIZE)) u_port_1 (
    .clk        (clk),
    .rst        (rst),
    .idle_i     (w_idle),
    .en_i       (en_1),
    .we_i       (write_enable_1),
    .in_range_i (w_in_range_1),
    .rdata_i    (w_rdata_1),
    .wr_o       (w_wr_1),
    .data_o     (output_1),
    .valid_o    (valid_1)
  );

  dpram_port #(.WORD_SIZE(WORD_SIZE)) u_port_2 (
    .clk        (clk),
    .rst        (rst),
    .idle_i     (w_idle),
    .en_i       (en_2),
    .we_i       (write_enable_2),
    .in_range_i (w_in_range_2),
    .rdata_i    (w_rdata_2),
    .wr_o       (w_wr_2),
    .data_o     (output_2),
    .valid_o    (valid_2)
  );

endmodule
`default_nettype wire

// File: doc/dpram_bank.md
# dpram_bank

Parametrised true dual-port RAM bank with per-port byte-enable writes, a read-valid handshake and a built-in clear sequencer. It is the successor to the plain 64-bit dual-port `dram` and sits between the monitoring pipeline's trace/metadata producers and their consumers. It adds:
- deterministic zeroed contents after reset,
- defined same-address collision rules,
- an optional extra output register stage for timing closure.

## Interface
Parameters:
- `WORD_SIZE`, 64, data width in bits; must be a multiple of 8.
- `ADDR_SIZE`, 8, address width.
- `WORD_CAPACITY`, 2**ADDR_SIZE, number of words; must be ≤ 2**ADDR_SIZE.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `clear_req` in 1: start a clear sequence (honoured only in IDLE).
- `busy` out 1: clear sequence in progress; both ports are blocked.
- `en_1`, `en_2` in 1: port access request.
- `write_enable_1`, `write_enable_2` in 1: 1 = write, 0 = read; qualified by `en_x`.
- `byte_en_1`, `byte_en_2` in WORD_SIZE/8: write lane mask; lane i = bits [8i+7:8i].
- `address_1`, `address_2` in ADDR_SIZE: word address.
- `data_in_1`, `data_in_2` in WORD_SIZE: write data.
- `output_1`, `output_2` out WORD_SIZE: read data.
- `valid_1`, `valid_2` out 1: `output_x` holds the result of a read.
- `collision` out 1: one-cycle pulse when both ports wrote the same address.

## Operation
Clear FSM, states IDLE and CLEAR:
- `rst` forces CLEAR with the clear counter at 0. CLEAR is also the first state after `rst` deasserts.
- In CLEAR, one word per cycle is written with all zeros at the counter address, and the counter increments.
- After address WORD_CAPACITY-1 is written, the FSM goes to IDLE on the next edge.
- `clear_req` in IDLE sends the FSM to CLEAR with the counter at 0. `clear_req` in CLEAR is ignored.
- `rst` asserted mid-clear aborts the sequence; clearing restarts from address 0.
- `busy` = 1 whenever the state is CLEAR.

Port accesses:
- Accepted only when IDLE and `en_x` = 1. Requests during CLEAR are dropped; no valid is produced.
- Write: lanes with `byte_en_x[i]` = 1 are updated; other lanes keep their value. An all-zero mask is a no-op write.
- Read: `en_x` = 1 and `write_enable_x` = 0. It produces `valid_x` and `output_x` after the read latency.
- Writes never assert `valid_x`.
- Same-address read on one port and write on the other in the same cycle: the read returns the old data (read-first).
- Both ports write the same address in the same cycle:
  - For lanes enabled on both ports, port 1's data wins.
  - Lanes enabled on only one port take that port's data.
  - `collision` pulses high for one cycle, registered, one cycle after the writes.
- Both ports reading the same address is legal; no collision is flagged.
- Addresses ≥ WORD_CAPACITY: writes are ignored, and reads return zero with valid.

Reset values:
- `busy` = 1.
- `valid_1`, `valid_2`, `collision` = 0.
- `output_1`, `output_2` = 0.
- Memory array: not reset directly; zeroed by the CLEAR sequence.

## Timing
- Read latency L = 1 cycle: a request on edge N gives `output_x`/`valid_x` after edge N+1 (L = 2 with the macro below).
- `valid_x` is high for exactly one cycle per read. Back-to-back reads every cycle are supported: full throughput, no stalls in IDLE.
- `output_x` holds its last read value while `valid_x` = 0.
- A write on edge N is visible to a read issued on edge N+1.
- Clear duration is exactly WORD_CAPACITY cycles: `busy` rises at `rst`/`clear_req` and falls after the final clear write.
- A read accepted one cycle before `clear_req` still completes with valid.

## Configuration
- `DPRAM_OUTPUT_REG_EN` defined: one extra register stage on `output_x`, `valid_x` and `collision`. L = 2, and the collision pulse is 2 cycles after the writes. The extra stage resets to 0.
- `DPRAM_OUTPUT_REG_EN` undefined: L = 1, no extra stage.

## Structure
- Package `dpram_pkg`:
  - state enum `dpram_state_t` {IDLE, CLEAR};
  - localparam `BYTE_LANES` = WORD_SIZE/8;
  - function building a WORD_SIZE bit mask from a lane mask.
- Sub-module `dpram_port`: per-port request qualification, valid pipeline and optional output register. It is instantiated twice.
- The array, the clear FSM and the collision merge stay in the top module.

## Test plan
- Reset, then idle: `busy` is high for 256 cycles (64/8 config). Reads of addresses 0x00, 0x7F and 0xFF then return 0 with `valid_x` after L.
- Port 1 writes 0x1234567890abcdef to 0x00 with mask 0xFF. Port 2 reads 0x00 the next cycle and gets 0x1234567890abcdef with `valid_2`.
- Port 2 writes 0xdeadbeefabcd1234 to 0x02 with mask 0x0F over 0. A read returns 0x00000000abcd1234.
- Same cycle at 0x05: port 1 writes 0x11..11 with mask 0xFF, port 2 writes 0x22..22 with mask 0xF0. The read returns 0x1111111111111111, and `collision` pulses once.
- With 0x10 = 0xA5..A5: port 1 writes 0x5A..5A while port 2 reads 0x10 in the same cycle. Port 2 gets 0xA5..A5, and a later read gets 0x5A..5A.
- `clear_req` with reads issued during `busy`: no `valid_x` during the clear. Assert `rst` at clear count 100: the clear restarts and afterwards all data reads 0.
